// File: rtl/fetch_unit_buffered_pkg.sv
// Shared types and constants for the buffered fetch stage.
package fetch_pkg;

    localparam int MAX_ADDR_W  = 64;
    localparam int INSTR_BYTES = 4;
    localparam int COND_LSB    = 5;
    localparam int COND_MSB    = 23;
    localparam int UNCOND_MSB  = 25;

    // One prefetch FIFO slot: the fetched word and the PC it came from.
    typedef struct packed {
        logic [MAX_ADDR_W-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_buffered_if.sv
// Redirect and decode handshake between the fetch stage and the rest of the pipeline.
interface fetch_unit_buffered_if #(
    parameter int ADDR_W = 64
);
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_pc;
    logic [31:0]       redir_instr;
    logic              redir_uncond;

    logic              dec_valid;
    logic              dec_ready;
    logic [ADDR_W-1:0] dec_pc;
    logic [31:0]       dec_instr;

    // Fetch unit side: takes redirects, presents the FIFO head.
    modport master (
        input  redir_valid, redir_pc, redir_instr, redir_uncond, dec_ready,
        output dec_valid, dec_pc, dec_instr
    );

    // Pipeline side: issues redirects, consumes the FIFO head.
    modport slave (
        output redir_valid, redir_pc, redir_instr, redir_uncond, dec_ready,
        input  dec_valid, dec_pc, dec_instr
    );
endinterface

// File: rtl/fetch_unit_buffered_branch_target_calc.sv
// Branch target = base_pc + (sext(imm) << 2), built from the datapath leaf cells.

module condAddr19Extend (
    input  logic [18:0] condAddr19,
    output logic [63:0] extended
);
    assign extended = {{45{condAddr19[18]}}, condAddr19};
endmodule

module brAddr26Extend (
    input  logic [25:0] brAddr26,
    output logic [63:0] extended
);
    assign extended = {{38{brAddr26[25]}}, brAddr26};
endmodule

module mux2_1_64 (
    input  logic [63:0] in0,
    input  logic [63:0] in1,
    input  logic        sel,
    output logic [63:0] result
);
    assign result = sel ? in1 : in0;
endmodule

module shiftLeftByTwo (
    input  logic [63:0] value,
    output logic [63:0] shifted
);
    assign shifted = value << 2;
endmodule

module fullAdder_64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum
);
    assign sum = a + b;
endmodule

module branch_target_calc
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int COND_W   = 19,
    parameter int UNCOND_W = 26
) (
    input  logic [ADDR_W-1:0] base_pc,
    input  logic [31:0]       instr,
    input  logic              uncond,
    output logic [ADDR_W-1:0] target
);
    logic [COND_W-1:0]   condField;
    logic [UNCOND_W-1:0] brField;
    logic [63:0]         basePc64;
    logic [63:0]         condExt;
    logic [63:0]         brExt;
    logic [63:0]         immSel;
    logic [63:0]         immShifted;
    logic [63:0]         sum64;
    logic                unusedOpcode;

    // Opcode bits above the widest immediate never affect the target.
    assign unusedOpcode = ^instr[31:UNCOND_MSB+1];

    assign condField = instr[COND_MSB:COND_LSB];
    assign brField   = instr[UNCOND_MSB:0];
    assign basePc64  = 64'(base_pc);

    condAddr19Extend u_condExt (.condAddr19(condField), .extended(condExt));
    brAddr26Extend   u_brExt   (.brAddr26(brField), .extended(brExt));
    mux2_1_64        u_immMux  (.in0(condExt), .in1(brExt), .sel(uncond), .result(immSel));
    shiftLeftByTwo   u_shift   (.value(immSel), .shifted(immShifted));
    fullAdder_64     u_add     (.a(basePc64), .b(immShifted), .sum(sum64));

    // Truncation makes the add modulo 2^ADDR_W; unaligned low bits pass through.
    assign target = sum64[ADDR_W-1:0];
endmodule

// File: rtl/fetch_unit_buffered.sv
// IF stage: PC register, instruction ROM read, show-ahead prefetch FIFO and redirect flush.

// Stand-in instruction ROM: combinational, contents are a fixed function of the address.
module instructmem (
    input  logic [63:0] address,
    output logic [31:0] instr
);
    localparam logic [31:0] ROM_SEED = 32'h9E37_79B9;
    assign instr = address[31:0] ^ address[63:32] ^ ROM_SEED;
endmodule

module fetch_unit_buffered
    import fetch_pkg::*;
#(
    parameter int              ADDR_W      = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int              FETCH_DEPTH = 4,
    parameter int              COND_W      = 19,
    parameter int              UNCOND_W    = 26
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           fetch_en,
    fetch_unit_buffered_if.master          bus,
    output logic [$clog2(FETCH_DEPTH):0]   fifo_count,
    output logic [ADDR_W-1:0]              fetch_pc
);
    localparam int PTR_W = $clog2(FETCH_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t      fifoMem [FETCH_DEPTH];
    fetch_entry_t      headEntry;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] pcReg;
    logic [ADDR_W-1:0] pcPlus4;
    logic [ADDR_W-1:0] target;
    logic [31:0]       memInstr;
    logic              pop;
    logic              push;

    instructmem u_imem (
        .address (64'(pcReg)),
        .instr   (memInstr)
    );

    branch_target_calc #(
        .ADDR_W   (ADDR_W),
        .COND_W   (COND_W),
        .UNCOND_W (UNCOND_W)
    ) u_btc (
        .base_pc (bus.redir_pc),
        .instr   (bus.redir_instr),
        .uncond  (bus.redir_uncond),
        .target  (target)
    );

    assign pcPlus4       = pcReg + ADDR_W'(INSTR_BYTES);
    assign bus.dec_valid = (count != '0);
    assign pop           = bus.dec_valid & bus.dec_ready;
    // A pop frees a slot at the same edge, so a full FIFO keeps streaming at one word per cycle.
    assign push          = fetch_en & ~bus.redir_valid & ((count < CNT_W'(FETCH_DEPTH)) | pop);
    assign headEntry     = fifoMem[rdPtr];
    assign fifo_count    = count;
    assign fetch_pc      = pcReg;

    // PC, pointers and occupancy: reset, then redirect flush, then normal push/pop.
    always_ff @(posedge clk) begin
        // NOTE: all state is updated with <= so every register samples pre-edge values.
        if (reset) begin
            pcReg <= RESET_PC;
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
        end else if (bus.redir_valid) begin
            pcReg <= target;
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
        end else begin
            if (push) begin
                pcReg <= pcPlus4;
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage write; the ROM word is captured at the edge it is read.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count=0 already marks every slot empty.
        if (!reset && push) begin
            fifoMem[wrPtr] <= '{pc: MAX_ADDR_W'(pcReg), instr: memInstr};
        end
    end

    // Show-ahead head output, forced to zero while the FIFO is empty.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        bus.dec_pc    = '0;
        bus.dec_instr = '0;
        if (bus.dec_valid) begin
            bus.dec_pc    = headEntry.pc[ADDR_W-1:0];
            bus.dec_instr = headEntry.instr;
        end
    end
endmodule

// File: tb/tb_fetch_unit_buffered.sv
// Directed, table-driven bench for fetch_unit_buffered.
module tb_fetch_unit_buffered;

    typedef struct {
        logic        rst;
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [63:0] rpc;
        logic [31:0] rinstr;
        logic        ru;
        logic        expValid;
        logic [63:0] expPc;
        logic [2:0]  expCnt;
        logic [63:0] expFpc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetchEn;
    logic [2:0]  fifoCount;
    logic [2:0]  fifoCount2;
    logic [63:0] fetchPc;
    logic [63:0] fetchPc2;
    int          errors = 0;
    int          checks = 0;
    vec_t        vecs[$];

    always #5 clk = ~clk;

    fetch_unit_buffered_if #(.ADDR_W(64)) bus ();
    fetch_unit_buffered_if #(.ADDR_W(64)) bus2 ();

    fetch_unit_buffered #(
        .ADDR_W(64), .RESET_PC(64'h0), .FETCH_DEPTH(4), .COND_W(19), .UNCOND_W(26)
    ) dut (
        .clk(clk), .reset(reset), .fetch_en(fetchEn), .bus(bus.master),
        .fifo_count(fifoCount), .fetch_pc(fetchPc)
    );

    fetch_unit_buffered #(
        .ADDR_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .FETCH_DEPTH(4), .COND_W(19), .UNCOND_W(26)
    ) dut2 (
        .clk(clk), .reset(reset), .fetch_en(fetchEn), .bus(bus2.master),
        .fifo_count(fifoCount2), .fetch_pc(fetchPc2)
    );

    // Contents of the stand-in instruction ROM.
    function automatic logic [31:0] instrOf(input logic [63:0] pc);
        return pc[31:0] ^ pc[63:32] ^ 32'h9E37_79B9;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t step(input logic fe, input logic rdy, input logic ev,
                                  input logic [63:0] epc, input logic [2:0] ecnt,
                                  input logic [63:0] efpc);
        vec_t v;
        v = '{rst: 1'b0, fe: fe, rdy: rdy, rv: 1'b0, rpc: 64'h0, rinstr: 32'h0, ru: 1'b0,
              expValid: ev, expPc: epc, expCnt: ecnt, expFpc: efpc};
        return v;
    endfunction

    function automatic vec_t redir(input logic [63:0] rpc, input logic [31:0] rinstr,
                                   input logic ru, input logic fe, input logic rdy,
                                   input logic [63:0] efpc);
        vec_t v;
        v = '{rst: 1'b0, fe: fe, rdy: rdy, rv: 1'b1, rpc: rpc, rinstr: rinstr, ru: ru,
              expValid: 1'b0, expPc: 64'h0, expCnt: 3'd0, expFpc: efpc};
        return v;
    endfunction

    function automatic vec_t rstv(input logic fe, input logic rdy);
        vec_t v;
        v = '{rst: 1'b1, fe: fe, rdy: rdy, rv: 1'b0, rpc: 64'h0, rinstr: 32'h0, ru: 1'b0,
              expValid: 1'b0, expPc: 64'h0, expCnt: 3'd0, expFpc: 64'h0};
        return v;
    endfunction

    initial begin
        int cycles;

        // Streaming from reset with decode always ready.
        vecs.push_back(step(1, 1, 1, 64'h00, 1, 64'h04));
        vecs.push_back(step(1, 1, 1, 64'h04, 1, 64'h08));
        vecs.push_back(step(1, 1, 1, 64'h08, 1, 64'h0C));
        vecs.push_back(step(1, 1, 1, 64'h0C, 1, 64'h10));
        vecs.push_back(step(1, 1, 1, 64'h10, 1, 64'h14));
        vecs.push_back(step(1, 1, 1, 64'h14, 1, 64'h18));
        vecs.push_back(rstv(0, 0));
        // Fill to full, stall, then one simultaneous pop+push.
        vecs.push_back(step(1, 0, 1, 64'h00, 1, 64'h04));
        vecs.push_back(step(1, 0, 1, 64'h00, 2, 64'h08));
        vecs.push_back(step(1, 0, 1, 64'h00, 3, 64'h0C));
        vecs.push_back(step(1, 0, 1, 64'h00, 4, 64'h10));
        vecs.push_back(step(1, 0, 1, 64'h00, 4, 64'h10));
        vecs.push_back(step(1, 1, 1, 64'h04, 4, 64'h14));
        // Unconditional redirect while full and ready: flush, no pop.
        vecs.push_back(redir(64'h100, 32'hFC00_0010, 1, 1, 1, 64'h140));
        vecs.push_back(step(1, 0, 1, 64'h140, 1, 64'h144));
        // Conditional redirect with negative offset (-2 words).
        vecs.push_back(redir(64'h40, 32'hB4FF_FFDF, 0, 1, 1, 64'h38));
        vecs.push_back(step(1, 0, 1, 64'h38, 1, 64'h3C));
        vecs.push_back(step(1, 0, 1, 64'h38, 2, 64'h40));
        vecs.push_back(step(1, 0, 1, 64'h38, 3, 64'h44));
        // Reset with three entries buffered.
        vecs.push_back(rstv(1, 1));
        // fetch_en low holds the PC; pops still drain.
        vecs.push_back(step(0, 1, 0, 64'h00, 0, 64'h00));
        vecs.push_back(step(1, 0, 1, 64'h00, 1, 64'h04));
        vecs.push_back(step(0, 1, 0, 64'h00, 0, 64'h04));
        // Back-to-back redirects: the second one wins.
        vecs.push_back(redir(64'h1000, 32'hFFFF_FFFF, 1, 1, 1, 64'hFFC));
        vecs.push_back(redir(64'h200, 32'h0000_0020, 0, 1, 1, 64'h204));
        vecs.push_back(step(1, 1, 1, 64'h204, 1, 64'h208));
        // Unaligned redirect target, fill through pointer wrap, then drain in order.
        vecs.push_back(redir(64'h103, 32'h0000_0000, 0, 1, 0, 64'h103));
        vecs.push_back(step(1, 0, 1, 64'h103, 1, 64'h107));
        vecs.push_back(step(1, 0, 1, 64'h103, 2, 64'h10B));
        vecs.push_back(step(1, 0, 1, 64'h103, 3, 64'h10F));
        vecs.push_back(step(1, 0, 1, 64'h103, 4, 64'h113));
        vecs.push_back(step(0, 1, 1, 64'h107, 3, 64'h113));
        vecs.push_back(step(0, 1, 1, 64'h10B, 2, 64'h113));
        vecs.push_back(step(0, 1, 1, 64'h10F, 1, 64'h113));
        vecs.push_back(step(0, 1, 0, 64'h000, 0, 64'h113));

        reset            = 1'b1;
        fetchEn          = 1'b0;
        bus.dec_ready    = 1'b0;
        bus.redir_valid  = 1'b0;
        bus.redir_pc     = '0;
        bus.redir_instr  = '0;
        bus.redir_uncond = 1'b0;
        bus2.dec_ready    = 1'b1;
        bus2.redir_valid  = 1'b0;
        bus2.redir_pc     = '0;
        bus2.redir_instr  = '0;
        bus2.redir_uncond = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset fetch_pc", fetchPc, 64'h0);
        check("reset count", 64'(fifoCount), 64'd0);
        check("reset dec_valid", 64'(bus.dec_valid), 64'd0);
        check("reset dec_pc", bus.dec_pc, 64'h0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            reset            = vecs[i].rst;
            fetchEn          = vecs[i].fe;
            bus.dec_ready    = vecs[i].rdy;
            bus.redir_valid  = vecs[i].rv;
            bus.redir_pc     = vecs[i].rpc;
            bus.redir_instr  = vecs[i].rinstr;
            bus.redir_uncond = vecs[i].ru;
            @(posedge clk);
            #1;
            check($sformatf("v%0d dec_valid", i), 64'(bus.dec_valid), 64'(vecs[i].expValid));
            check($sformatf("v%0d count", i), 64'(fifoCount), 64'(vecs[i].expCnt));
            check($sformatf("v%0d fetch_pc", i), fetchPc, vecs[i].expFpc);
            if (vecs[i].expValid) begin
                check($sformatf("v%0d dec_pc", i), bus.dec_pc, vecs[i].expPc);
                check($sformatf("v%0d dec_instr", i), 64'(bus.dec_instr), 64'(instrOf(vecs[i].expPc)));
            end
        end
        bus.redir_valid = 1'b0;
        reset           = 1'b0;

        // PC wrap past the top of the address space (second instance).
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("wrap reset fetch_pc", fetchPc2, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap reset count", 64'(fifoCount2), 64'd0);
        reset         = 1'b0;
        fetchEn       = 1'b1;
        bus.dec_ready = 1'b1;
        @(posedge clk);
        #1;
        check("wrap w0 dec_valid", 64'(bus2.dec_valid), 64'd1);
        check("wrap w0 dec_pc", bus2.dec_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap w0 dec_instr", 64'(bus2.dec_instr), 64'(instrOf(64'hFFFF_FFFF_FFFF_FFFC)));
        check("wrap w0 fetch_pc", fetchPc2, 64'h0);
        @(posedge clk);
        #1;
        check("wrap w1 dec_pc", bus2.dec_pc, 64'h0);
        check("wrap w1 dec_instr", 64'(bus2.dec_instr), 64'(instrOf(64'h0)));
        check("wrap w1 fetch_pc", fetchPc2, 64'h4);
        check("wrap w1 count", 64'(fifoCount2), 64'd1);

        // Fill from reset with decode stalled: bounded wait for full, then PC must hold.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset         = 1'b0;
        fetchEn       = 1'b1;
        bus.dec_ready = 1'b0;
        cycles        = 0;
        while (fifoCount != 3'd4 && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("fill cycles to full", 64'(cycles), 64'd4);
        check("fill fetch_pc", fetchPc, 64'h10);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d fetch_pc", k), fetchPc, 64'h10);
            check($sformatf("stall%0d count", k), 64'(fifoCount), 64'd4);
            check($sformatf("stall%0d dec_pc", k), bus.dec_pc, 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
